inst_fetch_queue: RTL and testbench

Instruction fetch stage that sits directly upstream of the single-cycle MIPS execute core. It owns the program counter used for fetch and issues word reads to a synchronous instruction ROM. Returned words are buffered with their PCs in a small prefetch queue and handed to the core over a valid/ready handshake. It also accepts branch/jump redirects from the core and stops fetching after a `syscall`.

---
 rtl/mips_pkg.sv | 32 +++
 rtl/inst_fetch_queue_if.sv | 39 +++
 rtl/inst_queue.sv | 57 +++++
 rtl/inst_fetch_queue.sv | 77 +++++++
 tb/tb_inst_fetch_queue.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS encoding constants and the fetch queue entry type.
// The opcode/funct constants are also used by the core's decoder.
package mips_pkg;

    localparam logic [5:0]  OP_RTYPE      = 6'b000000;
    localparam logic [5:0]  FUNCT_SYSCALL = 6'b001100;
    localparam logic [31:0] RESET_PC      = 32'h0000_0000;

    // Instruction field slice positions
    localparam int OP_MSB    = 31;
    localparam int OP_LSB    = 26;
    localparam int RS_MSB    = 25;
    localparam int RS_LSB    = 21;
    localparam int RT_MSB    = 20;
    localparam int RT_LSB    = 16;
    localparam int RD_MSB    = 15;
    localparam int RD_LSB    = 11;
    localparam int SHAMT_MSB = 10;
    localparam int SHAMT_LSB = 6;
    localparam int FUNCT_MSB = 5;
    localparam int FUNCT_LSB = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic is_syscall(input logic [5:0] op, input logic [5:0] funct);
        return (op == OP_RTYPE) && (funct == FUNCT_SYSCALL);
    endfunction

endpackage

// File: rtl/inst_fetch_queue_if.sv
// Fetch-side bundle: instruction ROM port, redirect request and the
// valid/ready delivery channel towards the execute core.
interface inst_fetch_queue_if #(
    parameter int ROM_AW = 5
);
    logic [ROM_AW-1:0] rom_addr;
    logic [31:0]       rom_data;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [31:0]       out_pc;
    logic              halted;

    modport master (
        output rom_addr,
        input  rom_data,
        input  redirect_valid,
        input  redirect_pc,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc,
        output halted
    );

    modport slave (
        input  rom_addr,
        output rom_data,
        output redirect_valid,
        output redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc,
        input  halted
    );
endinterface

// File: rtl/inst_queue.sv
// Synchronous prefetch FIFO of {pc, instr}; head is read straight from the
// storage registers so nothing on the consumer side feeds back into it.
module inst_queue
    import mips_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  fetch_entry_t           push_data,
    output fetch_entry_t           head,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Push into a full queue only happens alongside a pop, which frees the slot being written.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

    assign head = (count != '0) ? mem[rd_ptr] : '0;

    overrun_a: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && !flush && (count == CW'(DEPTH))));

    underrun_a: assert property (@(posedge clk) disable iff (!rst_n)
        !(pop && (count == '0)));

endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch stage: owns the fetch PC, issues synchronous ROM reads under a
// queue credit, buffers returned words and handles redirects and syscall halt.
module inst_fetch_queue
    import mips_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter int          ROM_AW   = 5,
    parameter logic [31:0] RESET_PC = mips_pkg::RESET_PC
) (
    input  logic               CLK,
    input  logic               RESETn,
    inst_fetch_queue_if.master bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]   fetch_pc;
    logic [31:0]   inflight_pc;
    logic [31:0]   issue_pc;
    logic          inflight;
    logic          halted;
    logic          halt_now;
    logic          issue;
    logic          push;
    logic          pop;
    logic [CW-1:0] count;
    fetch_entry_t  head;
    fetch_entry_t  push_entry;

    // Credits include the outstanding read so a returning word always has a slot.
    always_comb begin
        issue_pc   = bus.redirect_valid ? (bus.redirect_pc & ~32'h3) : fetch_pc;
        halt_now   = inflight && is_syscall(bus.rom_data[OP_MSB:OP_LSB],
                                            bus.rom_data[FUNCT_MSB:FUNCT_LSB]);
        issue      = bus.redirect_valid ||
                     (!halted && !halt_now && ((count + CW'(inflight)) < CW'(DEPTH)));
        push       = inflight && !bus.redirect_valid;
        pop        = (count != '0) && bus.out_ready;
        push_entry = {inflight_pc, bus.rom_data};
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            fetch_pc <= RESET_PC;
            inflight <= 1'b0;
            halted   <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) fetch_pc <= issue_pc + 32'd4;
            if (bus.redirect_valid) halted <= 1'b0;
            else if (halt_now)      halted <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (issue) inflight_pc <= issue_pc;
    end

    inst_queue #(
        .DEPTH(DEPTH)
    ) u_queue (
        .clk      (CLK),
        .rst_n    (RESETn),
        .flush    (bus.redirect_valid),
        .push     (push),
        .pop      (pop),
        .push_data(push_entry),
        .head     (head),
        .count    (count)
    );

    assign bus.rom_addr  = issue_pc[ROM_AW+1:2];
    assign bus.out_valid = (count != '0);
    assign bus.out_pc    = head.pc;
    assign bus.out_instr = head.instr;
    assign bus.halted    = halted;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: directed scenarios plus randomized traffic,
// all checked against a queue-based model of the fetch rules.
module tb_inst_fetch_queue;
    localparam int AW = 5;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic CLK = 1'b0;
    logic RESETn = 1'b0;
    always #5 CLK = ~CLK;

    inst_fetch_queue_if #(.ROM_AW(AW)) bus();

    inst_fetch_queue #(
        .DEPTH   (4),
        .ROM_AW  (AW),
        .RESET_PC(32'h0)
    ) dut (
        .CLK   (CLK),
        .RESETn(RESETn),
        .bus   (bus)
    );

    logic [31:0] rom [32];
    initial bus.rom_data = 32'h0;
    always @(posedge CLK) bus.rom_data <= rom[bus.rom_addr];

    int n_checks = 0;
    int n_fail   = 0;

    ent_t        mq[$];
    logic [31:0] m_fetch_pc;
    logic [31:0] m_inflight_pc;
    logic        m_inflight;
    logic        m_halted;
    logic        saw_68, saw_6c;

    logic        obs_valid, obs_halted;
    logic [31:0] obs_pc, obs_instr;
    logic [AW-1:0] obs_addr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_fetch_pc    = 32'h0;
        m_inflight_pc = 32'h0;
        m_inflight    = 1'b0;
        m_halted      = 1'b0;
    endtask

    function automatic logic [31:0] model_addr_pc();
        return bus.redirect_valid ? {bus.redirect_pc[31:2], 2'b00} : m_fetch_pc;
    endfunction

    task automatic compare();
        logic [31:0] apc;
        apc = model_addr_pc();
        chk("out_valid", 32'(bus.out_valid), 32'(mq.size() > 0));
        if (mq.size() > 0) begin
            chk("out_pc", bus.out_pc, mq[0].pc);
            chk("out_instr", bus.out_instr, mq[0].instr);
        end
        chk("halted", 32'(bus.halted), 32'(m_halted));
        chk("rom_addr", 32'(bus.rom_addr), 32'(apc[AW+1:2]));
        obs_valid  = bus.out_valid;
        obs_halted = bus.halted;
        obs_pc     = bus.out_pc;
        obs_instr  = bus.out_instr;
        obs_addr   = bus.rom_addr;
    endtask

    task automatic model_step();
        logic [31:0] apc, word;
        logic pop, hn, iss, rv;
        rv   = bus.redirect_valid;
        apc  = model_addr_pc();
        pop  = (mq.size() > 0) && bus.out_ready;
        word = rom[m_inflight_pc[AW+1:2]];
        hn   = m_inflight && (word[31:26] == 6'h00) && (word[5:0] == 6'h0C);
        iss  = rv || (!m_halted && !hn && ((mq.size() + int'(m_inflight)) < 4));
        if (pop) begin
            if (mq[0].pc == 32'h68) saw_68 = 1'b1;
            if (mq[0].pc == 32'h6C) saw_6c = 1'b1;
            void'(mq.pop_front());
        end
        if (rv) mq.delete();
        else if (m_inflight) begin
            chk("no_overrun", 32'(mq.size() < 4), 32'd1);
            mq.push_back('{pc: m_inflight_pc, instr: word});
        end
        if (rv)      m_halted = 1'b0;
        else if (hn) m_halted = 1'b1;
        if (iss) begin
            m_fetch_pc    = apc + 32'd4;
            m_inflight_pc = apc;
        end
        m_inflight = iss;
    endtask

    task automatic cycle();
        #1;
        compare();
        model_step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic do_reset();
        RESETn = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        model_reset();
        @(negedge CLK);
        @(negedge CLK);
        RESETn = 1'b1;
    endtask

    task automatic redirect_cycle(input logic [31:0] pc);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = pc;
        cycle();
        bus.redirect_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rom[i] = 32'h2402_0000 | 32'(i);
        rom[0]  = 32'h2408_0000;
        rom[1]  = 32'h2409_0001;
        rom[26] = 32'h0000_000C;
        saw_68 = 1'b0;
        saw_6c = 1'b0;
        bus.out_ready      = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        model_reset();

        // Reset state
        @(negedge CLK);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_halted", 32'(bus.halted), 32'd0);
        chk("rst_rom_addr", 32'(bus.rom_addr), 32'd0);
        chk("rst_out_pc", bus.out_pc, 32'd0);
        chk("rst_out_instr", bus.out_instr, 32'd0);
        @(negedge CLK);
        RESETn = 1'b1;

        // First delivery latency and steady stream
        cycle();
        cycle();
        chk("t1_c1_valid", 32'(obs_valid), 32'd0);
        cycle();
        chk("t1_c2_valid", 32'(obs_valid), 32'd1);
        chk("t1_c2_pc", obs_pc, 32'h0);
        chk("t1_c2_instr", obs_instr, 32'h2408_0000);
        cycle();
        chk("t1_c3_pc", obs_pc, 32'h4);
        chk("t1_c3_instr", obs_instr, 32'h2409_0001);
        for (int k = 2; k < 8; k++) begin
            cycle();
            chk("t1_stream_valid", 32'(obs_valid), 32'd1);
            chk("t1_stream_pc", obs_pc, 32'(4 * k));
        end

        // Backpressure fills the queue, then drains in order
        do_reset();
        bus.out_ready = 1'b0;
        repeat (10) cycle();
        chk("t2_rom_addr_stable", 32'(obs_addr), 32'd4);
        chk("t2_model_full", 32'(mq.size()), 32'd4);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("t2_drain_pc", obs_pc, 32'(4 * k));
        end

        // Redirect with 3 queued and one in flight
        do_reset();
        bus.out_ready = 1'b0;
        repeat (4) cycle();
        chk("t3_model_q3", 32'(mq.size()), 32'd3);
        chk("t3_model_inflight", 32'(m_inflight), 32'd1);
        redirect_cycle(32'h2C);
        bus.out_ready = 1'b1;
        cycle();
        chk("t3_flushed", 32'(obs_valid), 32'd0);
        cycle();
        chk("t3_target_valid", 32'(obs_valid), 32'd1);
        chk("t3_target_pc", obs_pc, 32'h2C);
        chk("t3_target_instr", obs_instr, 32'h2402_000B);

        // Syscall at 0x68 halts fetch
        do_reset();
        saw_68 = 1'b0;
        saw_6c = 1'b0;
        redirect_cycle(32'h60);
        repeat (12) cycle();
        chk("t4_saw_68", 32'(saw_68), 32'd1);
        chk("t4_no_6c", 32'(saw_6c), 32'd0);
        chk("t4_halted", 32'(obs_halted), 32'd1);
        chk("t4_addr_stopped", 32'(obs_addr), 32'd27);

        // Redirect out of halt
        redirect_cycle(32'h0);
        cycle();
        chk("t5_halt_clear", 32'(obs_halted), 32'd0);
        cycle();
        chk("t5_resume_valid", 32'(obs_valid), 32'd1);
        chk("t5_resume_pc", obs_pc, 32'h0);

        // Asynchronous reset mid-stream with a full queue
        bus.out_ready = 1'b0;
        repeat (8) cycle();
        #2;
        RESETn = 1'b0;
        #1;
        chk("t6_async_valid", 32'(bus.out_valid), 32'd0);
        model_reset();
        @(negedge CLK);
        @(negedge CLK);
        RESETn = 1'b1;
        bus.out_ready = 1'b1;
        cycle();
        cycle();
        chk("t6_c1_valid", 32'(obs_valid), 32'd0);
        cycle();
        chk("t6_c2_pc", obs_pc, 32'h0);
        chk("t6_c2_valid", 32'(obs_valid), 32'd1);

        // Misaligned redirect and ROM index aliasing
        do_reset();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h7E;
        cycle();
        bus.redirect_valid = 1'b0;
        chk("t7_addr31", 32'(obs_addr), 32'd31);
        cycle();
        chk("t7_addr_alias0", 32'(obs_addr), 32'd0);
        cycle();
        chk("t7_pc_7c", obs_pc, 32'h7C);
        chk("t7_instr_7c", obs_instr, 32'h2402_001F);
        cycle();
        chk("t7_pc_80", obs_pc, 32'h80);
        chk("t7_instr_80", obs_instr, 32'h2408_0000);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            bus.out_ready      = ($urandom_range(0, 3) != 0);
            bus.redirect_valid = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 9) == 0)
                bus.redirect_pc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            else
                bus.redirect_pc = 32'($urandom_range(0, 255));
            cycle();
        end
        bus.redirect_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
